// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU behind a valid/ready handshake; shifts run one bit per cycle.
// Optional feature: define ALU_SEQ_MUL_EN to build the shift-add multiplier for op 7.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             alu_zero,
  output logic             carry,
  output logic             neg
);
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_LSH = 3'd1, OP_RSH = 3'd2, OP_XOR = 3'd3,
    OP_SUB = 3'd4, OP_AND = 3'd5, OP_OR  = 3'd6, OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  state_e           state_r, state_s;
  op_e              op_r, op_s;
  logic [WIDTH-1:0] a_r, a_s, b_r, b_s, rslt_r, rslt_s;
  logic [SHW:0]     cnt_r, cnt_s;
  logic             zero_r, zero_s, carry_r, carry_s, neg_r, neg_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] fin_s;
  logic             fin_c_s, load_s;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH:0]   psum_s;

  // One partial-product step: the multiplier bit in b_r[0] gates the add of a_r.
  assign psum_s = {1'b0, hi_r} + (b_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
`endif

  // SUB reuses the adder as a + ~b + 1, so carry-out 1 means no borrow.
  assign sum_s = {1'b0, a_r} + {1'b0, (op_r == OP_SUB) ? ~b_r : b_r}
               + {{WIDTH{1'b0}}, (op_r == OP_SUB)};

  assign in_ready  = (state_r == S_IDLE);
  assign out_valid = (state_r == S_DONE);
  assign rslt      = rslt_r;
  assign alu_zero  = zero_r;
  assign carry     = carry_r;
  assign neg       = neg_r;

  // Next-state and datapath: every op spends cnt BUSY cycles, single-cycle ops use cnt = 1.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    cnt_s   = cnt_r;
    rslt_s  = rslt_r;
    zero_s  = zero_r;
    carry_s = carry_r;
    neg_s   = neg_r;
    fin_s   = {WIDTH{1'b0}};
    fin_c_s = 1'b0;
    load_s  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    hi_s    = hi_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          op_s    = op_e'(op);
          a_s     = in_a;
          b_s     = in_b;
          state_s = S_BUSY;
`ifdef ALU_SEQ_MUL_EN
          hi_s    = {WIDTH{1'b0}};
`endif
          case (op_e'(op))
            OP_LSH, OP_RSH: begin
              if (in_b[SHW-1:0] != {SHW{1'b0}}) begin
                cnt_s = {1'b0, in_b[SHW-1:0]};
              end else begin
                cnt_s = {{SHW{1'b0}}, 1'b1};
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  cnt_s = (SHW+1)'(WIDTH);
`endif
            default: cnt_s = {{SHW{1'b0}}, 1'b1};
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_s = cnt_r - {{SHW{1'b0}}, 1'b1};
        case (op_r)
          OP_ADD, OP_SUB: begin
            fin_s   = sum_s[WIDTH-1:0];
            fin_c_s = sum_s[WIDTH];
          end
          OP_XOR: fin_s = a_r ^ b_r;
          OP_AND: fin_s = a_r & b_r;
          OP_OR:  fin_s = a_r | b_r;
          OP_LSH: begin
            if (b_r[SHW-1:0] != {SHW{1'b0}}) begin
              {fin_c_s, fin_s} = {a_r, 1'b0};
            end else begin
              fin_s = a_r;
            end
            a_s = fin_s;
          end
          OP_RSH: begin
            if (b_r[SHW-1:0] != {SHW{1'b0}}) begin
              {fin_s, fin_c_s} = {1'b0, a_r};
            end else begin
              fin_s = a_r;
            end
            a_s = fin_s;
          end
          OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
            {hi_s, b_s} = {psum_s, b_r[WIDTH-1:1]};
            fin_s       = b_s;
            fin_c_s     = |hi_s;
`else
            fin_s       = {WIDTH{1'b0}};
`endif
          end
          default: fin_s = {WIDTH{1'b0}};
        endcase
        if (cnt_r == {{SHW{1'b0}}, 1'b1}) begin
          state_s = S_DONE;
          load_s  = 1'b1;
        end else begin
          state_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
    if (load_s) begin
      rslt_s  = fin_s;
      carry_s = fin_c_s;
      zero_s  = (fin_s == {WIDTH{1'b0}});
      neg_s   = fin_s[WIDTH-1];
    end else begin
      rslt_s  = rslt_r;
      carry_s = carry_r;
      zero_s  = zero_r;
      neg_s   = neg_r;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      op_r    <= OP_ADD;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      cnt_r   <= {(SHW+1){1'b0}};
      rslt_r  <= {WIDTH{1'b0}};
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
      neg_r   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_r    <= {WIDTH{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      cnt_r   <= cnt_s;
      rslt_r  <= rslt_s;
      zero_r  <= zero_s;
      carry_r <= carry_s;
      neg_r   <= neg_s;
`ifdef ALU_SEQ_MUL_EN
      hi_r    <= hi_s;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, hand-written corner sequences and randomized ops
// checked against an arithmetic reference model (WIDTH = 8).
module tb_alu_seq;
  logic       Clk = 1'b0;
  logic       Reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] in_a, in_b, rslt;
  logic       alu_zero, carry, neg;
  int         tests = 0;
  int         failed = 0;

  alu_seq #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .rslt(rslt), .alu_zero(alu_zero), .carry(carry), .neg(neg)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void model(input logic [2:0] o, input logic [7:0] a8, input logic [7:0] b8,
                                output logic [7:0] r, output logic c, output int lat);
    int a, b, n, p;
    a = a8; b = b8; n = b % 8; p = 0; c = 1'b0; lat = 1;
    case (o)
      3'd0: begin p = a + b; c = (p > 255); end
      3'd4: begin p = a - b; c = (a >= b); end
      3'd3: p = a ^ b;
      3'd5: p = a & b;
      3'd6: p = a | b;
      3'd1: begin
        p = a << n;
        if (n != 0) begin c = ((a >> (8 - n)) & 1) != 0; lat = n; end
      end
      3'd2: begin
        p = a >> n;
        if (n != 0) begin c = ((a >> (n - 1)) & 1) != 0; lat = n; end
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        p = a * b; c = (p > 255); lat = 8;
`else
        p = 0;
`endif
      end
    endcase
    r = 8'(p);
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic ez, input logic en,
                        input int el, input int hold, input string tag);
    int lat;
    @(negedge Clk);
    check({tag, " in_ready before"}, in_ready, 1);
    op = o; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge Clk); #1;
    // Garbage request while busy/done must be ignored.
    op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, el);
    check({tag, " rslt"}, rslt, er);
    check({tag, " carry"}, carry, ec);
    check({tag, " zero"}, alu_zero, ez);
    check({tag, " neg"}, neg, en);
    check({tag, " in_ready done"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk); #1;
      check({tag, " held valid"}, out_valid, 1);
      check({tag, " held rslt"}, {rslt, carry, alu_zero, neg}, {er, ec, ez, en});
      check({tag, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge Clk); #1;
    check({tag, " valid after accept"}, out_valid, 0);
    check({tag, " in_ready after accept"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[$];
    logic [2:0] ro;
    logic [7:0] ra, rb, er;
    logic       ec;
    int         el;

    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; in_a = 8'd0; in_b = 8'd0;
    #3 Reset = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset rslt", rslt, 0);
    check("reset flags", {alu_zero, carry, neg}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;

    vecs.push_back('{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd4, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{3'd4, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd1, 8'hB1, 8'h03, 8'h88, 1'b1, 1'b0, 1'b1, 3});
    vecs.push_back('{3'd2, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 7});
    vecs.push_back('{3'd2, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd1, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b1, 7});
    vecs.push_back('{3'd1, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{3'd3, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{3'd5, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd6, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0, 1'b0, 1});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{3'd7, 8'd20, 8'd20, 8'h90, 1'b1, 1'b0, 1'b1, 8});
`else
    vecs.push_back('{3'd7, 8'd20, 8'd20, 8'h00, 1'b0, 1'b1, 1'b0, 1});
`endif
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].n,
             vecs[i].lat, 0, $sformatf("vec%0d", i));

    // out_ready high in advance: DONE for exactly one cycle.
    @(negedge Clk);
    op = 3'd0; in_a = 8'd1; in_b = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1 in_valid = 1'b0;
    check("early_ready busy", out_valid, 0);
    @(posedge Clk); #1;
    check("early_ready valid", out_valid, 1);
    check("early_ready rslt", rslt, 8'd2);
    @(posedge Clk); #1;
    check("early_ready one cycle", out_valid, 0);
    check("early_ready in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Backpressure: result held for 5 cycles while new requests are ignored.
    run_op(3'd1, 8'hB1, 8'h03, 8'h88, 1'b1, 1'b0, 1'b1, 3, 5, "lsh_bp");

    // Reset at cycle 3 of a 7-step shift.
    @(negedge Clk);
    op = 3'd2; in_a = 8'h80; in_b = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge Clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check("midreset rslt", rslt, 0);
    check("midreset flags", {alu_zero, carry, neg}, 0);
    @(negedge Clk) Reset = 1'b0;
    run_op(3'd0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1, 0, "add_after_reset");

    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(ro, ra, rb, er, ec, el);
      run_op(ro, ra, rb, er, ec, (er == 8'd0), er[7], el, $urandom_range(0, 2),
             $sformatf("rnd%0d op%0d a%0h b%0h", i, ro, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
